// File: rtl/router_pkg.sv
// Shared router widths, receiver FSM states and header field helpers.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_LEN_W  = 6;
    localparam int ROUTER_ADDR_W = 2;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_REQ  = 2'd1,
        HDR_WAIT = 2'd2,
        BODY     = 2'd3
    } rx_state_t;

    function automatic logic [ROUTER_LEN_W-1:0] hdr_len(input logic [ROUTER_DATA_W-1:0] b);
        return b[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [ROUTER_ADDR_W-1:0] hdr_addr(input logic [ROUTER_DATA_W-1:0] b);
        return b[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_rx_parity.sv
// Running XOR of header and payload; mismatch compares it against the incoming parity byte.
// Accumulator updates one cycle after load/update; mismatch is combinational, no backpressure.
module router_rx_parity
    import router_pkg::*;
(
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     update,
    input  logic [ROUTER_DATA_W-1:0] din,
    output logic                     mismatch
);

    logic [ROUTER_DATA_W-1:0] acc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= din;
        end else if (update) begin
            acc <= acc ^ din;
        end
    end

    assign mismatch = (acc != din);

endmodule

// File: rtl/router_pkt_receiver.sv
// Router egress sink: drains one port FIFO at one byte/cycle, streams payload, checks parity.
// Stalls while vld_out is low; optional addr_err output under ROUTER_RX_ADDR_CHECK_EN.
module router_pkt_receiver
    import router_pkg::*;
#(
    parameter int START_DELAY = 0,
    parameter int PORT_ID     = 0
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     vld_out,
    input  logic [ROUTER_DATA_W-1:0] data_out,
    input  logic                     sft_rst,
    output logic                     read_enb,
    output logic [ROUTER_DATA_W-1:0] byte_out,
    output logic                     byte_valid,
    output logic                     pkt_done,
    output logic [ROUTER_LEN_W-1:0]  pkt_len,
    output logic [ROUTER_ADDR_W-1:0] pkt_addr,
    output logic                     parity_err,
    output logic                     pkt_abort,
    output logic [15:0]              pkt_cnt
`ifdef ROUTER_RX_ADDR_CHECK_EN
    ,
    output logic                     addr_err
`endif
);

    if (START_DELAY < 0 || START_DELAY > 15 || PORT_ID < 0 || PORT_ID > 3) begin : g_bad_param
        $error("router_pkt_receiver: START_DELAY must be 0..15 and PORT_ID 0..3");
    end

    localparam logic [3:0] DLY = 4'(START_DELAY);

    rx_state_t               state, state_nxt;
    logic [3:0]              dly_cnt;
    logic                    rd_pend;
    logic [ROUTER_LEN_W:0]   req_rem, rcv_rem;
    logic                    abort;
    logic                    body_byte;
    logic                    last_byte;
    logic                    par_mismatch;

    assign abort     = sft_rst && (state != IDLE);
    assign body_byte = (state == BODY) && rd_pend;
    assign last_byte = body_byte && (rcv_rem == 7'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read_enb  = 1'b0;
        case (state)
            IDLE: begin
                if (vld_out && !sft_rst && dly_cnt == DLY) state_nxt = HDR_REQ;
            end
            HDR_REQ: begin
                read_enb = vld_out;
                if (vld_out) state_nxt = HDR_WAIT;
            end
            HDR_WAIT: begin
                state_nxt = BODY;
            end
            BODY: begin
                read_enb = vld_out && (req_rem != '0);
                if (last_byte) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Start delay only accumulates over an unbroken run of vld_out in IDLE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dly_cnt <= '0;
        end else if (state != IDLE || !vld_out || sft_rst) begin
            dly_cnt <= '0;
        end else if (dly_cnt != DLY) begin
            dly_cnt <= dly_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_pend    <= 1'b0;
            req_rem    <= '0;
            rcv_rem    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
            parity_err <= 1'b0;
            pkt_abort  <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            byte_valid <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            if (abort) begin
                rd_pend   <= 1'b0;
                req_rem   <= '0;
                rcv_rem   <= '0;
                pkt_abort <= 1'b1;
            end else begin
                rd_pend <= read_enb;
                if (state == HDR_WAIT) begin
                    pkt_len  <= hdr_len(data_out);
                    pkt_addr <= hdr_addr(data_out);
                    req_rem  <= {1'b0, hdr_len(data_out)} + 7'd1;
                    rcv_rem  <= {1'b0, hdr_len(data_out)} + 7'd1;
                end
                if (state == BODY) begin
                    // A fired read and a consume in the same cycle both apply.
                    if (read_enb) req_rem <= req_rem - 7'd1;
                    if (rd_pend) rcv_rem <= rcv_rem - 7'd1;
                    if (last_byte) begin
                        parity_err <= par_mismatch;
                        pkt_done   <= 1'b1;
                        pkt_cnt    <= pkt_cnt + 16'd1;
                    end else if (body_byte) begin
                        byte_out   <= data_out;
                        byte_valid <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef ROUTER_RX_ADDR_CHECK_EN
    localparam logic [ROUTER_ADDR_W-1:0] PORT = 2'(PORT_ID);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_err <= 1'b0;
        end else if (last_byte && !abort) begin
            addr_err <= (pkt_addr != PORT) || (pkt_addr == 2'b11);
        end
    end
`endif

    router_rx_parity u_parity (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (abort),
        .load     ((state == HDR_WAIT) && !abort),
        .update   (body_byte && !last_byte && !abort),
        .din      (data_out),
        .mismatch (par_mismatch)
    );

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Directed bench: FIFO model feeding the receiver, with hand-computed packet expectations.
module tb_router_pkt_receiver;
    import router_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        vld_out = 1'b0;
    logic [7:0]  data_out = 8'h00;
    logic        sft_rst = 1'b0;
    logic        read_enb, byte_valid, pkt_done, parity_err, pkt_abort;
    logic [7:0]  byte_out;
    logic [5:0]  pkt_len;
    logic [1:0]  pkt_addr;
    logic [15:0] pkt_cnt;
`ifdef ROUTER_RX_ADDR_CHECK_EN
    logic        addr_err;
    logic        last_aerr = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  fifo[$];
    logic [7:0]  got[$];
    logic        hold = 1'b0;
    int          n_reads = 0, n_bad_rd = 0, n_done = 0, n_abort = 0;
    logic        last_perr = 1'b0;
    logic [5:0]  last_len = '0;
    logic [1:0]  last_addr = '0;

    always #5 clock = ~clock;

    router_pkt_receiver #(.START_DELAY(0), .PORT_ID(0)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .sft_rst    (sft_rst),
        .read_enb   (read_enb),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .parity_err (parity_err),
        .pkt_abort  (pkt_abort),
        .pkt_cnt    (pkt_cnt)
`ifdef ROUTER_RX_ADDR_CHECK_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    // Port FIFO model: read data appears the cycle after the read edge.
    always @(posedge clock) begin
        if (read_enb) begin
            n_reads++;
            if (!vld_out) n_bad_rd++;
            if (fifo.size() != 0) data_out <= fifo.pop_front();
        end
    end

    always @(negedge clock) begin
        vld_out = (fifo.size() != 0) && !hold;
        if (byte_valid) got.push_back(byte_out);
        if (pkt_abort) n_abort++;
        if (pkt_done) begin
            n_done++;
            last_perr = parity_err;
            last_len  = pkt_len;
            last_addr = pkt_addr;
`ifdef ROUTER_RX_ADDR_CHECK_EN
            last_aerr = addr_err;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload is 0..len-1; flip selects a corrupted parity (xor 0x07).
    task automatic push_pkt(input logic [7:0] hdr, input bit flip);
        logic [7:0] p;
        p = hdr;
        fifo.push_back(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            fifo.push_back(8'(i));
            p = p ^ 8'(i);
        end
        fifo.push_back(flip ? (p ^ 8'h07) : p);
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 400 && n_done == d0; c++) begin
            @(posedge clock); #2;
        end
        repeat (2) @(posedge clock);
        #2;
    endtask

    function automatic int order_errs();
        int e;
        e = 0;
        foreach (got[i]) if (got[i] != 8'(i)) e++;
        return e;
    endfunction

    int r0, d0, a0, stall_hi;
    bit stalled;

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pulses", {read_enb, byte_valid, pkt_done, pkt_abort, parity_err}, 0);
        check("rst_cnt", pkt_cnt, 0);
        check("rst_fields", {pkt_len, pkt_addr, byte_out}, 0);
        resetn = 1'b1;

        // len 17, addr 0, good parity 0x54
        @(posedge clock); #1;
        r0 = n_reads; d0 = n_done; got.delete();
        push_pkt(8'h44, 1'b0);
        wait_done(d0);
        check("p1_done", n_done - d0, 1);
        check("p1_reads", n_reads - r0, 19);
        check("p1_nbytes", got.size(), 17);
        check("p1_order", order_errs(), 0);
        check("p1_perr", last_perr, 0);
        check("p1_len", last_len, 17);
        check("p1_cnt", pkt_cnt, 1);
`ifdef ROUTER_RX_ADDR_CHECK_EN
        check("p1_aerr", last_aerr, 0);
`endif

        // same packet, parity 0x53
        r0 = n_reads; d0 = n_done; got.delete();
        push_pkt(8'h44, 1'b1);
        wait_done(d0);
        check("p2_done", n_done - d0, 1);
        check("p2_reads", n_reads - r0, 19);
        check("p2_perr", last_perr, 1);
        check("p2_cnt", pkt_cnt, 2);

        // zero-length packet, addr 1
        r0 = n_reads; d0 = n_done; got.delete();
        push_pkt(8'h01, 1'b0);
        wait_done(d0);
        check("p3_done", n_done - d0, 1);
        check("p3_reads", n_reads - r0, 2);
        check("p3_nbytes", got.size(), 0);
        check("p3_perr", last_perr, 0);
        check("p3_addr", last_addr, 1);
        check("p3_len", last_len, 0);
        check("p3_cnt", pkt_cnt, 3);

        // vld_out stall after payload byte 5
        r0 = n_reads; d0 = n_done; got.delete();
        stalled = 1'b0; stall_hi = 0;
        push_pkt(8'h44, 1'b0);
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #2;
            if (!stalled && got.size() >= 6) begin
                hold = 1'b1;
                repeat (3) begin
                    @(negedge clock); #1;
                    if (read_enb) stall_hi++;
                end
                hold = 1'b0;
                stalled = 1'b1;
            end
            if (n_done != d0) break;
        end
        wait_done(d0);
        check("st_stalled", stalled, 1);
        check("st_rd_low", stall_hi, 0);
        check("st_reads", n_reads - r0, 19);
        check("st_nbytes", got.size(), 17);
        check("st_order", order_errs(), 0);
        check("st_perr", last_perr, 0);
        check("st_cnt", pkt_cnt, 4);

        // soft reset during payload byte 7
        d0 = n_done; a0 = n_abort; got.delete();
        push_pkt(8'h44, 1'b0);
        for (int c = 0; c < 400 && got.size() < 8; c++) begin
            @(posedge clock); #2;
        end
        sft_rst = 1'b1;
        @(posedge clock); #1;
        sft_rst = 1'b0;
        fifo.delete();
        repeat (3) @(posedge clock);
        #2;
        check("sr_abort", n_abort - a0, 1);
        check("sr_nodone", n_done - d0, 0);
        check("sr_cnt", pkt_cnt, 4);
        check("sr_idle", int'(dut.state), int'(IDLE));
        check("sr_rd", read_enb, 0);

        // clean packet after the abort
        r0 = n_reads; d0 = n_done; got.delete();
        push_pkt(8'h44, 1'b0);
        wait_done(d0);
        check("ar_done", n_done - d0, 1);
        check("ar_reads", n_reads - r0, 19);
        check("ar_order", order_errs() + got.size(), 17);
        check("ar_perr", last_perr, 0);
        check("ar_cnt", pkt_cnt, 5);

`ifdef ROUTER_RX_ADDR_CHECK_EN
        // header 0x46: addr 2 on port 0
        d0 = n_done; got.delete();
        push_pkt(8'h46, 1'b0);
        wait_done(d0);
        check("ac_done", n_done - d0, 1);
        check("ac_perr", last_perr, 0);
        check("ac_addr", last_addr, 2);
        check("ac_aerr", last_aerr, 1);
        check("ac_nbytes", got.size(), 17);
`endif

        // reset mid-packet: no completion, no abort, count cleared
        d0 = n_done; a0 = n_abort; got.delete();
        push_pkt(8'h44, 1'b0);
        for (int c = 0; c < 400 && got.size() < 3; c++) begin
            @(posedge clock); #2;
        end
        resetn = 1'b0;
        fifo.delete();
        repeat (2) @(posedge clock);
        #1;
        check("mr_cnt", pkt_cnt, 0);
        check("mr_nodone", n_done - d0, 0);
        check("mr_noabort", n_abort - a0, 0);
        check("mr_idle", int'(dut.state), int'(IDLE));
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        check("no_empty_read", n_bad_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
